// File: rtl/sram_mem_ctrl_pkg.sv
// Shared constants and types for the MEM-stage SRAM controller.
// EXE and the hazard logic also import SRAM_BASE_ADDR from here.
package sram_mem_ctrl_pkg;

  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
  localparam int unsigned SRAM_AW_DEF    = 18;
  localparam int unsigned SRAM_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } sram_state_e;

  // Byte offset of an access relative to the SRAM window (no range check).
  function automatic logic [31:0] sram_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYC-1 while enabled and wraps,
// flagging the final cycle of the phase.
import sram_mem_ctrl_pkg::*;

module sram_phase_counter #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  output logic [SRAM_CNT_W-1:0] cnt_o,
  output logic                  last_o
);

  localparam logic [SRAM_CNT_W-1:0] LAST_CNT = SRAM_CNT_W'(WAIT_CYC - 1);

  logic [SRAM_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance and wrap on the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + SRAM_CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: splits each 32-bit access into two halfword
// transactions on an asynchronous 16-bit SRAM; ready=0 freezes the pipeline.
import sram_mem_ctrl_pkg::*;

module sram_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR,
  parameter int unsigned WAIT_CYC  = 2,
  parameter int unsigned SRAM_AW   = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  sram_state_e           state_q, state_d;
  logic                  op_wr_q, op_wr_d;
  logic [SRAM_AW-2:0]    word_q, word_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           offs;
  logic [SRAM_CNT_W-1:0] cnt;
  logic                  last;
  logic                  in_phase;
  logic                  unused_offs;

  assign offs        = sram_offset(address, BASE_ADDR);
  assign unused_offs = ^{offs[31:SRAM_AW+1], offs[1:0]};
  assign in_phase    = (state_q == ST_LOW) || (state_q == ST_HIGH);

  sram_phase_counter #(
    .WAIT_CYC (WAIT_CYC)
  ) u_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (!in_phase),
    .en_i    (in_phase),
    .cnt_o   (cnt),
    .last_o  (last)
  );

  // Next-state and datapath capture: latch the request in IDLE, step through
  // the two halfword phases, capture read halves on each phase's last cycle.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          op_wr_d = wr_en;
          word_d  = offs[SRAM_AW:2];
          wdata_d = write_data;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (last) begin
          if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (last) begin
          if (!op_wr_q) rdata_d[31:16] = sram_dq_in;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pin drive: WE_n is released on each phase's last cycle so address
  // and data are stable across its rising edge.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (in_phase) begin
      sram_addr = {word_q, (state_q == ST_HIGH)};
      if (op_wr_q) begin
        sram_dq_out = (state_q == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = last;
      end else begin
        sram_oe_n   = 1'b0;
      end
    end
  end

  assign ready     = (state_q == ST_DONE) ||
                     ((state_q == ST_IDLE) && !rd_en && !wr_en);
  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl with a behavioural async SRAM model.
module tb_sram_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic        rd_en4, wr_en4;
  logic [31:0] address4, write_data4, read_data4;
  logic        ready4;
  logic [17:0] sram_addr4;
  logic [15:0] sram_dq_out4, sram_dq_in4;
  logic        sram_dq_oe4, sram_we_n4, sram_oe_n4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] mem [64];
  logic [31:0] exp_q [$];
  logic [33:0] wexp_q [$];
  logic [33:0] wlog [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_mem_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYC(2), .SRAM_AW(18)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_mem_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYC(4), .SRAM_AW(18)) u_dut4 (
    .clk(clk), .rst(rst), .rd_en(rd_en4), .wr_en(wr_en4), .address(address4),
    .write_data(write_data4), .read_data(read_data4), .ready(ready4),
    .sram_addr(sram_addr4), .sram_dq_out(sram_dq_out4), .sram_dq_oe(sram_dq_oe4),
    .sram_dq_in(sram_dq_in4), .sram_we_n(sram_we_n4), .sram_oe_n(sram_oe_n4)
  );

  // Async SRAM: combinational read while OE_n low, write on WE_n rising edge.
  assign sram_dq_in  = (!sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0000;
  assign sram_dq_in4 = (!sram_oe_n4) ? ~sram_addr4[15:0] : 16'h0000;

  always @(posedge sram_we_n) begin
    if (rst === 1'b0) begin
      mem[sram_addr[5:0]] = sram_dq_out;
      wlog.push_back({sram_addr, sram_dq_out});
    end
  end

  // Drive one request from posedge+1, wait (bounded) for ready, record strobes.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output int at_cyc,
                           output logic [31:0] rdat, output logic [15:0] oe_mask,
                           output logic [15:0] oen_mask);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    lat = -1; at_cyc = -1; rdat = '0; oe_mask = '0; oen_mask = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 16) begin
        oe_mask[i]  = sram_dq_oe;
        oen_mask[i] = ~sram_oe_n;
      end
      if (ready === 1'b1) begin
        lat = i; at_cyc = cyc; rdat = read_data;
        break;
      end
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    rd_en4 = 1'b0; wr_en4 = 1'b0; address4 = '0; write_data4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if ({sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b110) begin n_err++; $display("FAIL reset_strobes: got %b want 110", {sram_we_n, sram_oe_n, sram_dq_oe}); end
    n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", read_data); end
    n_cmp++; if ({sram_addr, sram_dq_out} !== 34'h0) begin n_err++; $display("FAIL reset_addr_dq: got %h/%h want 0/0", sram_addr, sram_dq_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    wlog.delete();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ready, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110) begin
        n_err++; $display("FAIL idle_cycle%0d: got %b want 1110", i, {ready, sram_we_n, sram_oe_n, sram_dq_oe});
      end
    end
    n_cmp++; if (wlog.size() !== 0) begin n_err++; $display("FAIL idle_writes: got %0d want 0", wlog.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    int lat, at; logic [31:0] rd, exp; logic [15:0] om, onm;
    exp_q.push_back(32'hBEEF1234);
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, lat, at, rd, om, onm);
    exp = exp_q.pop_front();
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL read_latency: got %0d want 5", lat); end
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL read_data: got %h want %h", rd, exp); end
    n_cmp++; if (onm !== 16'h001E) begin n_err++; $display("FAIL read_oe_n: got %h want 001e", onm); end
    n_cmp++; if (om !== 16'h0000) begin n_err++; $display("FAIL read_dq_oe: got %h want 0000", om); end
    @(negedge clk);
    n_cmp++; if (read_data !== exp) begin n_err++; $display("FAIL read_hold: got %h want %h", read_data, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int lat, at; logic [31:0] rd; logic [15:0] om, onm; logic [33:0] e, g;
    wlog.delete();
    wexp_q.push_back({18'd2, 16'h0001});
    wexp_q.push_back({18'd3, 16'hCAFE});
    do_access(1'b0, 1'b1, 32'd1028, 32'hCAFE0001, lat, at, rd, om, onm);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL write_latency: got %0d want 5", lat); end
    n_cmp++; if (om !== 16'h001E) begin n_err++; $display("FAIL write_dq_oe: got %h want 001e", om); end
    n_cmp++; if (onm !== 16'h0000) begin n_err++; $display("FAIL write_oe_n: got %h want 0000", onm); end
    n_cmp++; if (rd !== 32'hBEEF1234) begin n_err++; $display("FAIL write_keeps_rdata: got %h want beef1234", rd); end
    n_cmp++; if (wlog.size() !== 2) begin n_err++; $display("FAIL write_pulses: got %0d want 2", wlog.size()); end
    while (wexp_q.size() > 0) begin
      e = wexp_q.pop_front();
      g = (wlog.size() > 0) ? wlog.pop_front() : 34'h3_FFFF_FFFF;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL write_strobe: got addr %0d data %h want addr %0d data %h", g[33:16], g[15:0], e[33:16], e[15:0]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, at0, at1, s; logic [31:0] rd, exp; logic [15:0] om, onm;
    s = cyc;
    do_access(1'b0, 1'b1, 32'd1032, 32'hA5A55A5A, lat, at0, rd, om, onm);
    exp_q.push_back(32'hA5A55A5A);
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, lat, at1, rd, om, onm);
    exp = exp_q.pop_front();
    n_cmp++; if (at0 - s !== 5) begin n_err++; $display("FAIL b2b_first_ready: got %0d want 5", at0 - s); end
    n_cmp++; if (at1 - s !== 11) begin n_err++; $display("FAIL b2b_second_ready: got %0d want 11", at1 - s); end
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL b2b_data: got %h want %h", rd, exp); end
    wlog.delete();
  endtask

  task automatic test_both();
    int lat, at; logic [31:0] rd, exp; logic [15:0] om, onm; logic [33:0] e, g;
    wlog.delete();
    wexp_q.push_back({18'd0, 16'hF00D});
    wexp_q.push_back({18'd1, 16'h0BAD});
    do_access(1'b1, 1'b1, 32'd1024, 32'h0BADF00D, lat, at, rd, om, onm);
    n_cmp++; if (onm !== 16'h0000) begin n_err++; $display("FAIL both_oe_n: got %h want 0000", onm); end
    n_cmp++; if (om !== 16'h001E) begin n_err++; $display("FAIL both_dq_oe: got %h want 001e", om); end
    while (wexp_q.size() > 0) begin
      e = wexp_q.pop_front();
      g = (wlog.size() > 0) ? wlog.pop_front() : 34'h3_FFFF_FFFF;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL both_strobe: got addr %0d data %h want addr %0d data %h", g[33:16], g[15:0], e[33:16], e[15:0]); end
    end
    exp_q.push_back(32'h0BADF00D);
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, lat, at, rd, om, onm);
    exp = exp_q.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL both_readback: got %h want %h", rd, exp); end
  endtask

  task automatic test_reset_mid();
    int lat, at; logic [31:0] rd, exp; logic [15:0] om, onm;
    rd_en = 1'b1; address = 32'd1028;
    repeat (4) @(negedge clk);
    n_cmp++; if ({sram_addr, sram_oe_n} !== {18'd3, 1'b0}) begin n_err++; $display("FAIL mid_in_high: got addr %0d oe_n %b want 3/0", sram_addr, sram_oe_n); end
    rst = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ready, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110) begin n_err++; $display("FAIL mid_reset_strobes: got %b want 1110", {ready, sram_we_n, sram_oe_n, sram_dq_oe}); end
    n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL mid_reset_rdata: got %h want 0", read_data); end
    n_cmp++; if (sram_addr !== 18'd0) begin n_err++; $display("FAIL mid_reset_addr: got %0d want 0", sram_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(32'hCAFE0001);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, lat, at, rd, om, onm);
    exp = exp_q.pop_front();
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL mid_after_latency: got %0d want 5", lat); end
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL mid_after_data: got %h want %h", rd, exp); end
  endtask

  task automatic test_wait4();
    int lat; logic [31:0] rd, exp;
    lat = -1; rd = '0;
    exp_q.push_back({~16'd11, ~16'd10});
    rd_en4 = 1'b1; address4 = 32'd1044;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready4 === 1'b1) begin lat = i; rd = read_data4; break; end
    end
    @(posedge clk); #1;
    rd_en4 = 1'b0;
    exp = exp_q.pop_front();
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL wait4_latency: got %0d want 9", lat); end
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL wait4_data: got %h want %h", rd, exp); end
    n_cmp++; if ({sram_we_n4, sram_dq_oe4, sram_dq_out4} !== {2'b10, 16'h0}) begin n_err++; $display("FAIL wait4_idle_pins: got %b/%b/%h want 1/0/0000", sram_we_n4, sram_dq_oe4, sram_dq_out4); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;
    mem[1] = 16'hBEEF;
    test_reset();
    test_idle();
    test_read();
    test_write();
    test_back_to_back();
    test_both();
    test_reset_mid();
    test_wait4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
